// File: rtl/mem_arbiter_if.sv
// Bus bundle between the arbiter, its two requesters (IF, MEM) and the
// byte-wide RAM/IO port. The slave side is the arbiter itself.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32
);
  // instruction fetch requester
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_cancel;
  logic              if_done;
  logic [31:0]       if_data;
  // memory stage requester
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  // byte-wide RAM/IO port
  logic [7:0]        ram_din;
  logic [7:0]        ram_dout;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_wr;

  modport slave (
    input  if_req, if_addr, if_cancel,
    output if_done, if_data,
    input  mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    output mem_done, mem_rdata,
    input  ram_din,
    output ram_dout, ram_addr, ram_wr
  );

  modport master (
    output if_req, if_addr, if_cancel,
    input  if_done, if_data,
    output mem_req, mem_we, mem_len, mem_addr, mem_wdata,
    input  mem_done, mem_rdata,
    output ram_din,
    input  ram_dout, ram_addr, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: shares one byte-wide synchronous RAM/IO port
// between instruction fetch (4-byte reads) and the memory stage (1/2/4-byte
// loads/stores). Accesses are split into byte beats, assembled/disassembled
// little-endian, and finished with a one-cycle done pulse. All outputs are
// registered; rdy low freezes the whole block.
module mem_arbiter #(
  parameter int         ADDR_W     = 32,
  parameter logic [1:0] IO_MASK_HI = 2'b11
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rdy_i,
  mem_arbiter_if.slave  bus,
  output logic          busy_o,
  output logic          io_busy_o
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        n_q, n_d;        // beats in this access (1, 2 or 4)
  logic [2:0]        cyc_q, cyc_d;    // edges since acceptance, minus one
  logic              is_if_q, is_if_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       acc_q, acc_d;    // read assembly buffer
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [7:0]        ram_dout_q, ram_dout_d;
  logic              ram_wr_q, ram_wr_d;
  logic              if_done_q, if_done_d;
  logic [31:0]       if_data_q, if_data_d;
  logic              mem_done_q, mem_done_d;
  logic [31:0]       mem_rdata_q, mem_rdata_d;
  logic              busy_q, busy_d;
  logic              io_busy_q, io_busy_d;
  logic [2:0]        beat;            // index of the edge being taken now

  function automatic logic [2:0] len_to_n(input logic [1:0] len);
    case (len)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;  // 10 is treated as a word
    endcase
  endfunction

  assign beat = cyc_q + 3'd1;

  // Next-state logic; with rdy low every register keeps its value.
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    n_d         = n_q;
    cyc_d       = cyc_q;
    is_if_d     = is_if_q;
    wdata_d     = wdata_q;
    acc_d       = acc_q;
    ram_addr_d  = ram_addr_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = if_done_q;
    if_data_d   = if_data_q;
    mem_done_d  = mem_done_q;
    mem_rdata_d = mem_rdata_q;
    busy_d      = busy_q;
    io_busy_d   = io_busy_q;

    if (rdy_i) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // RAM pins parked at 0 so no I/O register is touched by accident
          ram_addr_d = '0;
          ram_dout_d = '0;
          ram_wr_d   = 1'b0;
          if (bus.mem_req) begin
            base_d     = bus.mem_addr;
            n_d        = len_to_n(bus.mem_len);
            is_if_d    = 1'b0;
            wdata_d    = bus.mem_wdata;
            acc_d      = '0;
            cyc_d      = '0;
            ram_addr_d = bus.mem_addr;
            if (bus.mem_we) begin
              state_d    = WR;
              ram_wr_d   = 1'b1;
              ram_dout_d = bus.mem_wdata[7:0];
            end else begin
              state_d = RD;
            end
          end else if (bus.if_req) begin
            base_d     = bus.if_addr;
            n_d        = 3'd4;
            is_if_d    = 1'b1;
            acc_d      = '0;
            cyc_d      = '0;
            ram_addr_d = bus.if_addr;
            state_d    = RD;
          end
        end

        RD: begin
          if (is_if_q && bus.if_cancel) begin
            // flush wins even over the edge that would complete the fetch
            state_d    = IDLE;
            ram_addr_d = '0;
          end else begin
            cyc_d = beat;
            // RAM is synchronous: address of beat k is answered one cycle
            // later, so byte k is captured two edges after it was issued
            for (int b = 0; b < 4; b++)
              if (beat == 3'(b + 2)) acc_d[8*b +: 8] = bus.ram_din;
            if (beat < n_q) ram_addr_d = base_q + ADDR_W'(beat);
            else            ram_addr_d = '0;
            if (beat == n_q + 3'd1) begin
              state_d = DONE;
              if (is_if_q) begin
                if_done_d = 1'b1;
                if_data_d = acc_d;
              end else begin
                mem_done_d  = 1'b1;
                mem_rdata_d = acc_d;
              end
            end
          end
        end

        WR: begin
          cyc_d = beat;
          if (beat < n_q) begin
            ram_addr_d = base_q + ADDR_W'(beat);
            ram_wr_d   = 1'b1;
            ram_dout_d = '0;
            for (int b = 0; b < 4; b++)
              if (beat == 3'(b)) ram_dout_d = wdata_q[8*b +: 8];
          end else begin
            ram_addr_d = '0;
            ram_dout_d = '0;
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
            state_d    = DONE;
          end
        end

        default: begin  // DONE: one cycle, requests ignored
          state_d    = IDLE;
          ram_addr_d = '0;
          ram_dout_d = '0;
          ram_wr_d   = 1'b0;
        end
      endcase
      busy_d    = (state_d != IDLE);
      io_busy_d = busy_d && (base_d[17:16] == IO_MASK_HI);
    end
  end

  // State and registered outputs; reset abandons any access immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      base_q      <= '0;
      n_q         <= '0;
      cyc_q       <= '0;
      is_if_q     <= 1'b0;
      wdata_q     <= '0;
      acc_q       <= '0;
      ram_addr_q  <= '0;
      ram_dout_q  <= '0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      if_data_q   <= '0;
      mem_done_q  <= 1'b0;
      mem_rdata_q <= '0;
      busy_q      <= 1'b0;
      io_busy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      n_q         <= n_d;
      cyc_q       <= cyc_d;
      is_if_q     <= is_if_d;
      wdata_q     <= wdata_d;
      acc_q       <= acc_d;
      ram_addr_q  <= ram_addr_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      if_data_q   <= if_data_d;
      mem_done_q  <= mem_done_d;
      mem_rdata_q <= mem_rdata_d;
      busy_q      <= busy_d;
      io_busy_q   <= io_busy_d;
    end
  end

  assign bus.if_done   = if_done_q;
  assign bus.if_data   = if_data_q;
  assign bus.mem_done  = mem_done_q;
  assign bus.mem_rdata = mem_rdata_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.ram_wr    = ram_wr_q;
  assign busy_o        = busy_q;
  assign io_busy_o     = io_busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a synchronous byte RAM model gated
// by rdy. Outputs are sampled 1 time unit after each rising edge.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic busy, io_busy;
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter_if bus ();

  mem_arbiter dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .rdy_i     (rdy),
    .bus       (bus),
    .busy_o    (busy),
    .io_busy_o (io_busy)
  );

  always #5 clk = ~clk;

  // RAM: preload contents come from a fixed table; writes override them
  bit [7:0] ram [1024];
  bit       wrote [1024];

  function automatic logic [7:0] init_byte(input logic [9:0] a);
    case (a)
      10'h100: return 8'h13;
      10'h101: return 8'h05;
      10'h104: return 8'h93;
      10'h106: return 8'h10;
      10'h020: return 8'hAB;
      10'h200: return 8'h11;
      10'h201: return 8'h22;
      10'h202: return 8'h33;
      10'h203: return 8'h44;
      10'h040: return 8'h6F;
      10'h300: return 8'hDE;
      10'h301: return 8'hAD;
      10'h302: return 8'hBE;
      10'h303: return 8'hEF;
      10'h010: return 8'h5A;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] rd_byte(input logic [9:0] a);
    return wrote[a] ? ram[a] : init_byte(a);
  endfunction

  always @(posedge clk) begin
    if (rdy) begin
      if (bus.ram_wr) begin
        ram[bus.ram_addr[9:0]]   <= bus.ram_dout;
        wrote[bus.ram_addr[9:0]] <= 1'b1;
      end
      bus.ram_din <= rd_byte(bus.ram_addr[9:0]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req = 0; bus.if_addr = '0; bus.if_cancel = 0;
    bus.mem_req = 0; bus.mem_we = 0; bus.mem_len = 2'b00;
    bus.mem_addr = '0; bus.mem_wdata = '0;
    #22;
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ram_addr", bus.ram_addr, 0);
    chk("rst_ram_wr", {31'b0, bus.ram_wr}, 0);
    chk("rst_done", {30'b0, bus.if_done, bus.mem_done}, 0);
    chk("rst_data", bus.if_data | bus.mem_rdata, 0);
    rst_n = 1'b1;
    tick(); tick();

    // 1: IF word read at 0x100
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick(); chk("if_E0_addr", bus.ram_addr, 32'h100);
    chk("if_E0_busy", {31'b0, busy}, 1);
    chk("if_E0_io", {31'b0, io_busy}, 0);
    tick(); chk("if_E1_addr", bus.ram_addr, 32'h101);
    tick(); chk("if_E2_addr", bus.ram_addr, 32'h102);
    tick(); chk("if_E3_addr", bus.ram_addr, 32'h103);
    chk("if_E3_wr", {31'b0, bus.ram_wr}, 0);
    tick(); chk("if_E4_done", {31'b0, bus.if_done}, 0);
    tick(); chk("if_E5_done", {31'b0, bus.if_done}, 1);
    chk("if_E5_data", bus.if_data, 32'h0000_0513);
    bus.if_req = 0;
    tick(); chk("if_E6_done", {31'b0, bus.if_done}, 0);
    chk("if_E6_busy", {31'b0, busy}, 0);
    tick();

    // 2: simultaneous requests, MEM byte load wins
    bus.if_req = 1; bus.if_addr = 32'h104;
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_len = 2'b00; bus.mem_addr = 32'h20;
    tick(); chk("pri_E0_addr", bus.ram_addr, 32'h20);
    tick(); chk("pri_E1_addr", bus.ram_addr, 0);
    tick(); chk("pri_E2_mdone", {31'b0, bus.mem_done}, 1);
    chk("pri_E2_rdata", bus.mem_rdata, 32'h0000_00AB);
    chk("pri_E2_ifdone", {31'b0, bus.if_done}, 0);
    bus.mem_req = 0;
    tick(); chk("pri_E3_busy", {31'b0, busy}, 0);
    chk("pri_E3_addr", bus.ram_addr, 0);
    tick(); chk("pri_if_E0_addr", bus.ram_addr, 32'h104);
    chk("pri_if_E0_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 4; i++) tick();
    chk("pri_if_E4_done", {31'b0, bus.if_done}, 0);
    tick(); chk("pri_if_E5_done", {31'b0, bus.if_done}, 1);
    chk("pri_if_E5_data", bus.if_data, 32'h0010_0093);
    bus.if_req = 0;
    tick(); tick();

    // 3: half store 0x1234BEEF at 0x200
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_len = 2'b01;
    bus.mem_addr = 32'h200; bus.mem_wdata = 32'h1234_BEEF;
    tick(); chk("hs_E0_addr", bus.ram_addr, 32'h200);
    chk("hs_E0_dout", {24'b0, bus.ram_dout}, 32'hEF);
    chk("hs_E0_wr", {31'b0, bus.ram_wr}, 1);
    tick(); chk("hs_E1_addr", bus.ram_addr, 32'h201);
    chk("hs_E1_dout", {24'b0, bus.ram_dout}, 32'hBE);
    chk("hs_E1_wr", {31'b0, bus.ram_wr}, 1);
    tick(); chk("hs_E2_wr", {31'b0, bus.ram_wr}, 0);
    chk("hs_E2_addr", bus.ram_addr, 0);
    chk("hs_E2_done", {31'b0, bus.mem_done}, 1);
    bus.mem_req = 0; bus.mem_we = 0;
    tick(); chk("hs_E3_busy", {31'b0, busy}, 0);
    tick();
    chk("hs_ram200", {24'b0, rd_byte(10'h200)}, 32'hEF);
    chk("hs_ram201", {24'b0, rd_byte(10'h201)}, 32'hBE);
    chk("hs_ram202", {24'b0, rd_byte(10'h202)}, 32'h33);

    // 4: IF read cancelled at E3, then a clean fetch at 0x40
    bus.if_req = 1; bus.if_addr = 32'h100;
    tick(); tick(); tick();
    bus.if_cancel = 1; bus.if_req = 0;
    tick(); chk("cx_E3_busy", {31'b0, busy}, 0);
    chk("cx_E3_addr", bus.ram_addr, 0);
    chk("cx_E3_done", {31'b0, bus.if_done}, 0);
    bus.if_cancel = 0;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        seen = seen | bus.if_done;
      end
      chk("cx_no_done", {31'b0, seen}, 0);
    end
    bus.if_req = 1; bus.if_addr = 32'h40;
    for (int i = 0; i < 5; i++) tick();
    chk("cx_new_E4_done", {31'b0, bus.if_done}, 0);
    tick(); chk("cx_new_E5_done", {31'b0, bus.if_done}, 1);
    chk("cx_new_data", bus.if_data, 32'h0000_006F);
    bus.if_req = 0;
    tick(); tick();

    // 5: word load at 0x300 with rdy low for 3 cycles after E2
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_len = 2'b11; bus.mem_addr = 32'h300;
    tick(); tick(); tick();
    chk("rdy_E2_addr", bus.ram_addr, 32'h302);
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rdy_hold_addr", bus.ram_addr, 32'h302);
      chk("rdy_hold_st", {29'b0, busy, bus.ram_wr, bus.mem_done}, 32'b100);
    end
    rdy = 1;
    tick(); chk("rdy_E3_addr", bus.ram_addr, 32'h303);
    tick(); chk("rdy_E4_done", {31'b0, bus.mem_done}, 0);
    tick(); chk("rdy_E5_done", {31'b0, bus.mem_done}, 1);
    chk("rdy_E5_rdata", bus.mem_rdata, 32'hEFBE_ADDE);
    bus.mem_req = 0;
    tick(); tick();

    // io region byte load at 0x30010 (RAM model aliases to 0x010)
    bus.mem_req = 1; bus.mem_len = 2'b00; bus.mem_addr = 32'h0003_0010;
    tick(); chk("io_E0_io", {31'b0, io_busy}, 1);
    tick(); tick(); chk("io_E2_rdata", bus.mem_rdata, 32'h0000_005A);
    bus.mem_req = 0;
    tick(); chk("io_E3_io", {31'b0, io_busy}, 0);
    tick();

    // 6: reset during word store at E1
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_len = 2'b11;
    bus.mem_addr = 32'h400; bus.mem_wdata = 32'hCAFE_F00D;
    tick(); tick();
    chk("rs_E1_wr", {31'b0, bus.ram_wr}, 1);
    rst_n = 0;
    #1;
    chk("rs_async_wr", {31'b0, bus.ram_wr}, 0);
    chk("rs_async_busy", {31'b0, busy}, 0);
    bus.mem_req = 0; bus.mem_we = 0;
    tick(); tick();
    rst_n = 1;
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
        tick();
        seen = seen | bus.mem_done;
      end
      chk("rs_no_done", {31'b0, seen}, 0);
    end
    chk("rs_idle", {31'b0, busy}, 0);
    chk("rs_addr", bus.ram_addr, 0);
    chk("rs_ram400", {24'b0, rd_byte(10'h400)}, 32'h0D);
    chk("rs_ram401", {24'b0, rd_byte(10'h401)}, 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Sequences the single byte-wide RAM/IO port between two requesters: instruction fetch (IF, 4-byte reads only) and the memory stage (MEM, 1/2/4-byte loads and stores). Splits each access into byte beats, assembles or disassembles little-endian words, and returns a one-cycle done pulse. It sits between the IF/mem stages and the top-level ram pins, and replaces the combinational memory controller. Requesters stall until they see done.

Parameters:
ADDR_W, 32, address width of requester and RAM addresses.
IO_MASK_HI, 2'b11, value of addr[17:16] that marks the I/O region; used only for the io_busy flag.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
rdy  in  1  global ready; low freezes the block
if_req  in  1  IF read request; held high until if_done or cancel
if_addr  in  32  IF word address
if_cancel  in  1  branch flush; aborts the in-flight IF access
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched instruction
mem_req  in  1  MEM request; held high until mem_done
mem_we  in  1  1 = store, 0 = load
mem_len  in  2  00 byte, 01 half, 11 word (10 is treated as word)
mem_addr  in  32  MEM byte address
mem_wdata  in  32  store data, LSB first
mem_done  out  1  one-cycle pulse
mem_rdata  out  32  load data, zero-extended
ram_din  in  8  RAM read byte
ram_dout  out  8  RAM write byte
ram_addr  out  32  RAM byte address
ram_wr  out  1  RAM write strobe
busy  out  1  state != IDLE
io_busy  out  1  current access targets the I/O region

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; beat counters 0; data accumulator 0.
- All outputs are registered. Edge E0 is the edge that accepts a request; later edges are E1, E2, ...
- States: IDLE, RD, WR, DONE.
- IDLE -> RD/WR on a request. mem_req has priority over if_req when both are high. IF is RD with n=4. MEM uses n from mem_len.
- RD:
  - ram_addr = base+k is driven from edge Ek, for k=0..n-1, with ram_wr=0.
  - The byte for beat k is captured from ram_din at edge E(k+2) into bits [8k+7:8k].
  - At E(n+1): data is latched to if_data or mem_rdata, the matching done is set, and state goes to DONE.
  - Word read done at E5. Byte read done at E2.
- WR:
  - From edge Ek, k=0..n-1: ram_addr = base+k, ram_dout = wdata[8k+7:8k], ram_wr=1.
  - At En: ram_wr=0, ram_addr=0, mem_done=1, state goes to DONE.
  - Word store done at E4.
- DONE:
  - Lasts exactly one cycle with done high; requests are ignored.
  - Next edge: done=0, state=IDLE.
  - A request still high in IDLE starts a new access, so a requester must drop its request in the done cycle.
- When not in RD or WR: ram_addr=0, ram_wr=0, ram_dout=0. This avoids spurious I/O reads at 0x30000.
- Bytes above n in mem_rdata are 0. Sign extension is the mem stage's job.
- Address increments are computed modulo 2^32; no alignment check.
- if_cancel:
  - When sampled high at any edge while an IF RD is active: state goes to IDLE, ram_addr=0, and if_done is not raised.
  - This holds even at the edge that would have set if_done; cancel wins.
  - if_cancel has no effect on MEM accesses or in IDLE.
- rdy=0: state, counters, accumulator and all outputs hold their values. An in-flight read resumes without losing beats, because the RAM is gated by the same rdy.
- Reset asserted mid-access: the access is abandoned immediately and ram_wr drops asynchronously. No done pulse is produced.
- io_busy = busy && addr[17:16]==IO_MASK_HI.

Test Plan:
- IF read at 0x100, RAM bytes 13 05 00 00 -> ram_addr goes 0x100..0x103 at E0..E3; if_data=0x00000513 and if_done high for exactly one cycle after E5; busy low after E6.
- if_req and mem_req (byte load at 0x20, RAM byte 0xAB) both rise in the same cycle -> MEM served first with mem_rdata=0x000000AB at E2; IF access starts at the first IDLE edge after DONE.
- Half store of mem_wdata=0x1234BEEF at 0x200 -> EF at 0x200 on E0 and BE at 0x201 on E1 with ram_wr=1; ram_wr=0 and mem_done=1 at E2; byte 0x34 is never written.
- IF read with if_cancel pulsed at E3 -> state IDLE at E3, ram_addr=0, no if_done pulse; a new if_req at 0x40 completes normally.
- Word load with rdy low for 3 cycles at E2 -> all outputs frozen for those cycles; final mem_rdata is correct and mem_done is delayed by exactly 3 cycles.
- rst driven low at E1 of a word store -> ram_wr=0 with no clock edge; mem_done never pulses; the block is IDLE after rst is released.
